coproc_cmd_master: RTL and testbench

Host-side command initiator for the image zoom coprocessor. Accepts one command at a time from a valid/ready stream and drives the coprocessor's INSTRUCTION/MEM_ADDR/DATA_IN lines and its active-low ENABLE strobe. Tracks the FLAG_DONE busy/idle handshake and returns DATA_OUT plus the error and zoom-limit flags on a valid/ready response stream. Sits between the HPS/bus bridge and the coprocessor top; the coprocessor runs on its own PLL clock, so all flags it returns are synchronized here.

---
 rtl/coproc_pkg.sv | 36 +++
 rtl/coproc_cmd_master_flag_sync.sv | 25 ++
 rtl/coproc_cmd_master.sv | 200 ++++++++++++++++++++
 tb/tb_coproc_cmd_master.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the zoom-coprocessor command path: opcodes, FSM
// state encoding, image geometry and timer width.
package coproc_pkg;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_LOAD        = 3'd1,
        OP_STORE       = 3'd2,
        OP_ZOOM_IN_VP  = 3'd3,
        OP_ZOOM_IN_RP  = 3'd4,
        OP_ZOOM_OUT_MP = 3'd5,
        OP_ZOOM_OUT_VD = 3'd6,
        OP_RESET_INST  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_PULSE      = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_RESP       = 3'd6
    } state_t;

    localparam int unsigned IMG_PIXELS = 76800;
    localparam int unsigned ADDR_W     = 17;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned TMR_W      = 20;

    // NOP and RESET_INST complete without the coprocessor ever dropping FLAG_DONE.
    function automatic logic is_settle_op(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_RESET_INST);
    endfunction

endpackage

// File: rtl/coproc_cmd_master_flag_sync.sv
// Two-flop synchronizer for the coprocessor's flags and quasi-static DATA_OUT bus.
module flag_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/coproc_cmd_master.sv
// Host-side command initiator for the zoom coprocessor: one command in flight,
// ENABLE pulse generation, FLAG_DONE handshake tracking and response capture.
// Optional handshake timeouts are built when COPROC_TIMEOUT_EN is defined.
module coproc_cmd_master
    import coproc_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter int unsigned DONE_TIMEOUT  = 1048575,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_instruction,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [PIX_W-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PIX_W-1:0]  rsp_data,
    output logic              rsp_error,
    output logic              rsp_zoom_max,
    output logic              rsp_zoom_min,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [2:0]        instruction,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  data_in,
    output logic              enable_n,
    input  logic              flag_done,
    input  logic              flag_error,
    input  logic              flag_zoom_max,
    input  logic              flag_zoom_min,
    input  logic [PIX_W-1:0]  data_out
);

    localparam int unsigned SYNC_W = PIX_W + 4;

    state_t              state_d, state_q;
    logic [TMR_W-1:0]    cnt_d, cnt_q;
    logic [2:0]          instr_d, instr_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic [PIX_W-1:0]    wdata_d, wdata_q;
    logic [PIX_W-1:0]    rsp_data_d, rsp_data_q;
    logic                rsp_error_d, rsp_error_q;
    logic                rsp_zmax_d, rsp_zmax_q;
    logic                rsp_zmin_d, rsp_zmin_q;
    logic                rsp_timeout_d, rsp_timeout_q;
    logic                rsp_valid_d, rsp_valid_q;
    logic                enable_n_d, enable_n_q;
    logic                cmd_ready_d, cmd_ready_q;

    logic [SYNC_W-1:0]   sync_vec;
    logic                done_s, error_s, zmax_s, zmin_s;
    logic [PIX_W-1:0]    data_s;
    logic                accept;
    logic                pulse_last, settle_last;
    logic                ack_to, done_to;

    flag_sync #(
        .WIDTH(SYNC_W)
    ) u_flag_sync (
        .clock  (clock),
        .async_i({data_out, flag_zoom_min, flag_zoom_max, flag_error, flag_done}),
        .sync_o (sync_vec)
    );

    assign done_s  = sync_vec[0];
    assign error_s = sync_vec[1];
    assign zmax_s  = sync_vec[2];
    assign zmin_s  = sync_vec[3];
    assign data_s  = sync_vec[SYNC_W-1:4];

    assign accept      = cmd_valid && cmd_ready_q;
    assign pulse_last  = (cnt_q == TMR_W'(PULSE_CYCLES - 1));
    assign settle_last = (cnt_q == TMR_W'(SETTLE_CYCLES - 1));

`ifdef COPROC_TIMEOUT_EN
    assign ack_to  = (cnt_q >= TMR_W'(ACK_TIMEOUT - 1));
    assign done_to = (cnt_q >= TMR_W'(DONE_TIMEOUT - 1));
`else
    assign ack_to  = 1'b0;
    assign done_to = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            instr_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_zmax_q    <= 1'b0;
            rsp_zmin_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            enable_n_q    <= 1'b1;
            cmd_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_zmax_q    <= rsp_zmax_d;
            rsp_zmin_q    <= rsp_zmin_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            enable_n_q    <= enable_n_d;
            cmd_ready_q   <= cmd_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (accept) state_d = ST_WAIT_READY;
            ST_WAIT_READY: begin
                if (done_s)      state_d = ST_PULSE;
                else if (ack_to) state_d = ST_RESP;
            end
            ST_PULSE: begin
                if (pulse_last) state_d = is_settle_op(instr_q) ? ST_SETTLE : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!done_s)     state_d = ST_WAIT_DONE;
                else if (ack_to) state_d = ST_RESP;
            end
            ST_WAIT_DONE:  if (done_s || done_to) state_d = ST_RESP;
            ST_SETTLE:     if (settle_last) state_d = ST_RESP;
            ST_RESP:       if (rsp_ready) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from state_d so they change on the same edge as the state.
    always_comb begin
        instr_d       = instr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_zmax_d    = rsp_zmax_q;
        rsp_zmin_d    = rsp_zmin_q;
        rsp_timeout_d = rsp_timeout_q;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != {TMR_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        if (state_q == ST_IDLE && accept) begin
            instr_d = cmd_instruction;
            addr_d  = cmd_addr;
            wdata_d = cmd_data;
        end

        if (state_d == ST_RESP && state_q != ST_RESP) begin
            rsp_data_d    = '0;
            rsp_error_d   = 1'b0;
            rsp_zmax_d    = 1'b0;
            rsp_zmin_d    = 1'b0;
            rsp_timeout_d = 1'b0;
            if (state_q == ST_WAIT_DONE && done_s) begin
                rsp_data_d  = (instr_q == OP_LOAD) ? data_s : '0;
                rsp_error_d = error_s;
                rsp_zmax_d  = zmax_s;
                rsp_zmin_d  = zmin_s;
            end else if (state_q != ST_SETTLE) begin
                rsp_timeout_d = 1'b1;
            end
        end

        enable_n_d  = (state_d != ST_PULSE);
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_zoom_max = rsp_zmax_q;
    assign rsp_zoom_min = rsp_zmin_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = (state_q != ST_IDLE);
    assign instruction  = instr_q;
    assign mem_addr     = addr_q;
    assign data_in      = wdata_q;
    assign enable_n     = enable_n_q;

endmodule

// File: tb/tb_coproc_cmd_master.sv
// Self-checking bench for coproc_cmd_master with a behavioural coprocessor model.
module tb_coproc_cmd_master;
    import coproc_pkg::*;

    localparam int PULSE  = 2;
    localparam int ACKTO  = 16;
    localparam int SETTLE = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_instruction = '0;
    logic [16:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout;
    logic        busy;
    logic [2:0]  instruction;
    logic [16:0] mem_addr;
    logic [7:0]  data_in;
    logic        enable_n;
    logic        flag_done = 1'b1;
    logic        flag_error = 1'b0;
    logic        flag_zoom_max = 1'b0;
    logic        flag_zoom_min = 1'b0;
    logic [7:0]  data_out = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Coprocessor model controls
    bit          mdl_arm = 1'b0;
    bit          mdl_noack = 1'b0;
    int          mdl_ack_dly = 3;
    int          mdl_busy = 10;
    logic [7:0]  mdl_data = '0;
    bit          mdl_err = 1'b0, mdl_max = 1'b0, mdl_min = 1'b0;
    int          mdl_done_cyc = 0;

    coproc_cmd_master #(
        .PULSE_CYCLES (PULSE),
        .ACK_TIMEOUT  (ACKTO),
        .DONE_TIMEOUT (1048575),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_instruction(cmd_instruction),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .rsp_zoom_max   (rsp_zoom_max),
        .rsp_zoom_min   (rsp_zoom_min),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .instruction    (instruction),
        .mem_addr       (mem_addr),
        .data_in        (data_in),
        .enable_n       (enable_n),
        .flag_done      (flag_done),
        .flag_error     (flag_error),
        .flag_zoom_max  (flag_zoom_max),
        .flag_zoom_min  (flag_zoom_min),
        .data_out       (data_out)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Coprocessor: on ENABLE release, real work opcodes drop FLAG_DONE, run, then raise it.
    always begin
        @(posedge enable_n);
        if (mdl_arm && !mdl_noack && instruction != 3'd0 && instruction != 3'd7) begin
            repeat (mdl_ack_dly) @(negedge clock);
            flag_done = 1'b0;
            flag_error = 1'b0;
            flag_zoom_max = 1'b0;
            flag_zoom_min = 1'b0;
            repeat (mdl_busy) @(negedge clock);
            data_out = mdl_data;
            flag_error = mdl_err;
            flag_zoom_max = mdl_max;
            flag_zoom_min = mdl_min;
            @(negedge clock);
            flag_done = 1'b1;
            mdl_done_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Issue one command and observe it; indices count cycles after the accept cycle (cycle 0).
    task automatic run_cmd(input logic [2:0] op, input logic [16:0] a, input logic [7:0] d,
                           input int budget, output int first_low, output int low_cnt,
                           output int rel_idx, output int rsp_idx, output int rsp_abs,
                           output int low_abs, output int done_at_low, output bit stable_ok);
        int c0, idx, w;
        first_low = -1; low_cnt = 0; rel_idx = -1; rsp_idx = -1; rsp_abs = -1;
        low_abs = -1; done_at_low = -1; stable_ok = 1'b1;
        cmd_instruction = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        c0 = cyc;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_instruction = 3'($urandom);
        cmd_addr = 17'($urandom);
        cmd_data = 8'($urandom);
        for (int k = 0; k < budget; k++) begin
            idx = cyc - c0;
            if (instruction !== op || mem_addr !== a || data_in !== d || busy !== 1'b1)
                stable_ok = 1'b0;
            if (enable_n === 1'b0) begin
                if (first_low < 0) begin
                    first_low = idx;
                    low_abs = cyc;
                    done_at_low = mdl_done_cyc;
                end
                low_cnt++;
            end else if (low_cnt > 0 && rel_idx < 0) begin
                rel_idx = idx;
            end
            if (rsp_valid === 1'b1) begin
                rsp_idx = idx;
                rsp_abs = cyc;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clock);
        total++;
        if (enable_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_enable_n: got %b want 1", enable_n);
        end
        total++;
        if ({instruction, mem_addr, data_in, rsp_valid, rsp_data, rsp_error, rsp_zoom_max,
             rsp_zoom_min, rsp_timeout, busy, cmd_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: instr=%h addr=%h din=%h rv=%b rd=%h busy=%b rdy=%b want all 0",
                     instruction, mem_addr, data_in, rsp_valid, rsp_data, busy, cmd_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        mdl_arm = 1'b1;
    endtask

    task automatic test_store();
        int fl, lc, rel, ri, ra, la, dl;
        bit st;
        mdl_ack_dly = 3; mdl_busy = 10; mdl_data = 8'h99;
        mdl_err = 1'b0; mdl_max = 1'b0; mdl_min = 1'b0;
        run_cmd(OP_STORE, 17'h00123, 8'hA5, 80, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (fl !== 2 || lc !== PULSE) begin
            bad++;
            $display("FAIL store_pulse: first_low=%0d low_cycles=%0d want 2/%0d", fl, lc, PULSE);
        end
        total++;
        if (ri < 0 || rsp_timeout !== 1'b0 || rsp_data !== 8'h00 || enable_n !== 1'b1) begin
            bad++;
            $display("FAIL store_rsp: rsp_idx=%0d timeout=%b data=%h want response, 0, 00", ri, rsp_timeout, rsp_data);
        end
        total++;
        if (ra - mdl_done_cyc < 2 || ra - mdl_done_cyc > 3) begin
            bad++;
            $display("FAIL store_done_latency: got %0d cycles want 2..3", ra - mdl_done_cyc);
        end
        total++;
        if (!st) begin
            bad++;
            $display("FAIL store_hold: outputs not held, got instr=%h addr=%h din=%h", instruction, mem_addr, data_in);
        end
        take_rsp();
    endtask

    task automatic test_load();
        int fl, lc, rel, ri, ra, la, dl;
        bit st;
        mdl_ack_dly = 2; mdl_busy = 6; mdl_data = 8'h3C;
        run_cmd(OP_LOAD, 17'h12BFF, 8'h00, 80, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (ri < 0 || rsp_data !== 8'h3C || rsp_timeout !== 1'b0) begin
            bad++;
            $display("FAIL load_data: rsp_idx=%0d data=%h timeout=%b want 3c/0", ri, rsp_data, rsp_timeout);
        end
        take_rsp();
    endtask

    task automatic test_zoom_backpressure();
        int fl, lc, rel, ri, ra, la, dl;
        bit st, hold_ok;
        logic [11:0] snap;
        mdl_ack_dly = 1; mdl_busy = 8; mdl_data = 8'h5A;
        mdl_err = 1'b0; mdl_max = 1'b1; mdl_min = 1'b0;
        run_cmd(OP_ZOOM_IN_RP, 17'h00000, 8'h00, 80, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (ri < 0 || rsp_zoom_max !== 1'b1 || rsp_zoom_min !== 1'b0 || rsp_error !== 1'b0 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL zoom_flags: max=%b min=%b err=%b data=%h want 1/0/0/00", rsp_zoom_max, rsp_zoom_min, rsp_error, rsp_data);
        end
        snap = {rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout};
        cmd_valid = 1'b1;
        cmd_instruction = OP_STORE;
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if ({rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout} !== snap
                || rsp_valid !== 1'b1 || cmd_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        total++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL zoom_backpressure: rsp=%h valid=%b cmd_ready=%b want %h/1/0",
                     {rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}, rsp_valid, cmd_ready, snap);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zoom_no_bypass: rsp_valid=%b cmd_ready=%b busy=%b want 0/1/0", rsp_valid, cmd_ready, busy);
        end
        mdl_max = 1'b0;
        run_cmd(OP_NOP, 17'h00042, 8'h11, 40, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (ri < 0 || rel < 0 || ri - rel !== SETTLE || {rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout} !== 4'b0) begin
            bad++;
            $display("FAIL nop_settle: settle=%0d flags=%b want %0d/0000", ri - rel,
                     {rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}, SETTLE);
        end
        take_rsp();
    endtask

    task automatic test_reset_inst();
        int fl, lc, rel, ri, ra, la, dl;
        bit st;
        run_cmd(OP_RESET_INST, 17'h1FFFF, 8'hFF, 40, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (fl !== 2 || lc !== PULSE) begin
            bad++;
            $display("FAIL reset_inst_pulse: first_low=%0d low_cycles=%0d want 2/%0d", fl, lc, PULSE);
        end
        total++;
        if (ri < 0 || rel < 0 || ri - rel !== SETTLE) begin
            bad++;
            $display("FAIL reset_inst_settle: got %0d cycles after release want %0d", ri - rel, SETTLE);
        end
        total++;
        if ({rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout} !== 12'h000) begin
            bad++;
            $display("FAIL reset_inst_flags: got %h want 000", {rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout});
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        int fl, lc, rel, ri, ra, la, dl;
        bit st;
        mdl_noack = 1'b1;
        run_cmd(OP_STORE, 17'h00321, 8'h5A, 40, fl, lc, rel, ri, ra, la, dl, st);
`ifdef COPROC_TIMEOUT_EN
        total++;
        if (ri < 0 || rel < 0 || ri - rel !== ACKTO) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles after release want %0d", ri - rel, ACKTO);
        end
        total++;
        if (rsp_timeout !== 1'b1 || enable_n !== 1'b1 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL timeout_rsp: timeout=%b enable_n=%b data=%h want 1/1/00", rsp_timeout, enable_n, rsp_data);
        end
        take_rsp();
`else
        total++;
        if (ri !== -1 || enable_n !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL unbounded_wait: rsp_idx=%0d enable_n=%b busy=%b want -1/1/1", ri, enable_n, busy);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
`endif
        mdl_noack = 1'b0;
    endtask

    task automatic test_reset_mid_cmd();
        int fl, lc, rel, ri, ra, la, dl;
        bit st;
        int old_done;
        old_done = mdl_done_cyc;
        mdl_ack_dly = 2; mdl_busy = 14;
        run_cmd(OP_STORE, 17'h00777, 8'h12, 12, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (ri !== -1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_precond: rsp_idx=%0d busy=%b want -1/1", ri, busy);
        end
        reset_n = 1'b0;
        @(negedge clock);
        total++;
        if (enable_n !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: enable_n=%b rsp_valid=%b busy=%b want 1/0/0", enable_n, rsp_valid, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);
        mdl_busy = 6; mdl_data = 8'h77;
        run_cmd(OP_LOAD, 17'h0ABCD, 8'h00, 120, fl, lc, rel, ri, ra, la, dl, st);
        total++;
        if (fl <= 2 || dl === old_done || la - dl < 2) begin
            bad++;
            $display("FAIL midreset_wait_ready: first_low=%0d low_at=%0d done_rise=%0d want pulse after done rises",
                     fl, la, dl);
        end
        total++;
        if (ri < 0 || rsp_data !== 8'h77 || rsp_timeout !== 1'b0 || lc !== PULSE) begin
            bad++;
            $display("FAIL midreset_load: rsp_idx=%0d data=%h timeout=%b low=%0d want 77/0/%0d", ri, rsp_data, rsp_timeout, lc, PULSE);
        end
        take_rsp();
    endtask

    task automatic test_random();
        int fl, lc, rel, ri, ra, la, dl;
        bit st, hold_ok, settle_op;
        logic [2:0]  op;
        logic [16:0] a;
        logic [7:0]  d, exp_data;
        logic [3:0]  exp_flags;
        logic [11:0] snap;
        int bp;
        for (int it = 0; it < 16; it++) begin
            op = 3'($urandom_range(0, 7));
            a = 17'($urandom_range(0, IMG_PIXELS - 1));
            d = 8'($urandom);
            mdl_ack_dly = $urandom_range(1, 4);
            mdl_busy = $urandom_range(3, 12);
            mdl_data = 8'($urandom);
            mdl_err = 1'($urandom); mdl_max = 1'($urandom); mdl_min = 1'($urandom);
            settle_op = (op == 3'd0) || (op == 3'd7);
            exp_data = (op == 3'd1) ? mdl_data : 8'h00;
            exp_flags = settle_op ? 4'b0000 : {mdl_err, mdl_max, mdl_min, 1'b0};
            run_cmd(op, a, d, 80, fl, lc, rel, ri, ra, la, dl, st);
            total++;
            if (fl !== 2 || lc !== PULSE) begin
                bad++;
                $display("FAIL rnd%0d_pulse: op=%0d first_low=%0d low=%0d want 2/%0d", it, op, fl, lc, PULSE);
            end
            total++;
            if (ri < 0 || rsp_data !== exp_data || {rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout} !== exp_flags) begin
                bad++;
                $display("FAIL rnd%0d_rsp: op=%0d data=%h flags=%b want %h/%b", it, op, rsp_data,
                         {rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}, exp_data, exp_flags);
            end
            total++;
            if (settle_op ? (rel < 0 || ri - rel !== SETTLE) : (ra - mdl_done_cyc < 2 || ra - mdl_done_cyc > 3)) begin
                bad++;
                $display("FAIL rnd%0d_timing: op=%0d rel=%0d rsp=%0d done_gap=%0d", it, op, rel, ri, ra - mdl_done_cyc);
            end
            snap = {rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout};
            bp = $urandom_range(0, 3);
            hold_ok = st;
            for (int k = 0; k < bp; k++) begin
                @(negedge clock);
                if ({rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout} !== snap || rsp_valid !== 1'b1
                    || instruction !== op || mem_addr !== a || data_in !== d)
                    hold_ok = 1'b0;
            end
            total++;
            if (!hold_ok) begin
                bad++;
                $display("FAIL rnd%0d_hold: instr=%h addr=%h din=%h rsp=%h want %h/%h/%h/%h", it, instruction, mem_addr,
                         data_in, {rsp_data, rsp_error, rsp_zoom_max, rsp_zoom_min, rsp_timeout}, op, a, d, snap);
            end
            take_rsp();
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_store();
        test_load();
        test_zoom_backpressure();
        test_reset_inst();
        test_timeout();
        test_reset_mid_cmd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
